hamming_scrub_ctrl: RTL

//  Background scrubber for a memory of 13-bit Hamming SEC-DED codewords (8 data bits).
//  On start, walks addresses 0..DEPTH-1: reads, decodes via external combinational SEC-DED decoder,
//  re-encodes and writes back single-bit-corrected words, logs double-bit errors.

---
 rtl/hamming_scrub_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/hamming_scrub_ctrl.sv
// hamming_scrub_ctrl
// Background scrubber for a memory of 13-bit SEC-DED Hamming codewords.
// A pass walks addresses 0..DEPTH-1. Each word is read and checked by an
// external combinational decoder. Single-bit errors are re-encoded by an
// external encoder and written back. Double-bit errors are counted, and the
// address of the first one is logged. The scrubber shares the single memory
// port with a host. The host wins whenever the scrubber does not have a read
// in flight or a write-back pending.

module hamming_scrub_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              host_req,
  output logic              host_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [12:0]       mem_wr_code,
  input  logic [12:0]       mem_rd_code,
  output logic [12:0]       dec_code,
  input  logic [7:0]        dec_data,
  input  logic              dec_sec,
  input  logic              dec_ded,
  output logic [7:0]        enc_data,
  input  logic [12:0]       enc_code,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt,
  output logic [ADDR_W-1:0] ded_addr
);

  // The final address of a pass. DEPTH need not be a power of two.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CHK,
    S_WB,
    S_NEXT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [12:0] wb_code;

  // Per-cycle strobes from the FSM. They steer the datapath registers.
  logic clear_pass;
  logic step_addr;
  logic inc_sec;
  logic inc_ded;

  // The read word goes straight to the decoder. The corrected data byte
  // goes straight to the encoder, so the clean codeword is ready in CHK.
  assign dec_code = mem_rd_code;
  assign enc_data = dec_data;
  assign busy     = (state != S_IDLE);

  // Outside WB, the write data is held at zero so that the bus stays
  // quiet while the host owns the port.
  assign mem_wr_code = mem_wr_en ? wb_code : 13'd0;

  // State register. The reset is synchronous and aborts a pass at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, port arbitration and datapath strobes for the current state.
  always_comb begin
    state_next = state;
    host_gnt   = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    done       = 1'b0;
    clear_pass = 1'b0;
    step_addr  = 1'b0;
    inc_sec    = 1'b0;
    inc_ded    = 1'b0;
    case (state)
      S_IDLE: begin
        host_gnt = host_req;
        if (start) begin
          clear_pass = 1'b1;
          state_next = S_RD;
        end
      end
      S_RD: begin
        if (host_req) begin
          host_gnt = 1'b1;
        end else begin
          mem_rd_en  = 1'b1;
          state_next = S_CHK;
        end
      end
      S_CHK: begin
        if (dec_ded) begin
          inc_ded    = 1'b1;
          state_next = S_NEXT;
        end else if (dec_sec) begin
          inc_sec    = 1'b1;
          state_next = S_WB;
        end else begin
          state_next = S_NEXT;
        end
      end
      S_WB: begin
        mem_wr_en  = 1'b1;
        state_next = S_NEXT;
      end
      S_NEXT: begin
        host_gnt = host_req;
        if (mem_addr == LAST_ADDR) begin
          state_next = S_DONE;
        end else begin
          step_addr  = 1'b1;
          state_next = S_RD;
        end
      end
      S_DONE: begin
        host_gnt   = host_req;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers: scrub address, write-back codeword, and pass statistics.
  // The first DED of a pass is the one seen while ded_cnt is still zero.
  // The counter never wraps back to zero, so later DEDs cannot overwrite ded_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
      wb_code  <= '0;
      sec_cnt  <= '0;
      ded_cnt  <= '0;
      ded_addr <= '0;
    end else begin
      if (clear_pass) begin
        mem_addr <= '0;
        sec_cnt  <= '0;
        ded_cnt  <= '0;
        ded_addr <= '0;
      end
      if (step_addr) begin
        mem_addr <= mem_addr + ADDR_W'(1);
      end
      if (inc_sec) begin
        wb_code <= enc_code;
        if (sec_cnt != CNT_MAX) begin
          sec_cnt <= sec_cnt + CNT_W'(1);
        end
      end
      if (inc_ded) begin
        if (ded_cnt == '0) begin
          ded_addr <= mem_addr;
        end
        if (ded_cnt != CNT_MAX) begin
          ded_cnt <= ded_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Port-sharing invariants. Only one party drives the memory port in a cycle.
  a_rd_wr_excl : assert property (@(posedge clk) disable iff (rst)
    !(mem_rd_en && mem_wr_en));
  a_host_excl : assert property (@(posedge clk) disable iff (rst)
    !(host_gnt && (mem_rd_en || mem_wr_en)));
  a_addr_range : assert property (@(posedge clk) disable iff (rst)
    (mem_addr <= LAST_ADDR));

endmodule
